// File: rtl/alarm_responder_if.sv
// Signal bundle between the security FSM / keypad side and the alarm responder.
// The responder takes the slave modport; the driving side takes master.
interface alarm_responder_if #(
    parameter int CODE_W = 4
);
    logic              alarm_in;
    logic              code_valid;
    logic [CODE_W-1:0] code_in;
    logic              siren;
    logic              strobe;
    logic              escalate;
    logic              ack;
    logic [1:0]        state_o;
    logic [1:0]        bad_tries;
    logic [7:0]        alarm_count;

    modport slave (
        input  alarm_in, code_valid, code_in,
        output siren, strobe, escalate, ack, state_o, bad_tries, alarm_count
    );

    modport master (
        output alarm_in, code_valid, code_in,
        input  siren, strobe, escalate, ack, state_o, bad_tries, alarm_count
    );
endinterface

// File: rtl/alarm_responder.sv
// Alarm responder: turns the upstream alarm level into a pulsed siren and a strobe,
// escalates on timeout or repeated wrong codes, and is acknowledged by a keypad code.
module alarm_responder #(
    parameter int                CODE_W      = 4,
    parameter logic [CODE_W-1:0] DISARM_CODE = 4'h5,
    parameter int                BEEP_HALF   = 4,
    parameter int                ESC_CYCLES  = 32,
    parameter int                MAX_TRIES   = 3
) (
    input logic              clk,
    input logic              rst_n,
    alarm_responder_if.slave bus
);

    localparam int PHASE_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam int TIMER_W = (ESC_CYCLES > 1) ? $clog2(ESC_CYCLES) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BEEP_HALF - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ESC_CYCLES - 1);
    localparam logic [1:0]         TRIES_MAX  = 2'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_SOUNDING  = 2'b01,
        S_ESCALATED = 2'b10,
        S_ACKED     = 2'b11
    } state_t;

    state_t             r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [TIMER_W-1:0] r_timer;
    logic [1:0]         r_badTries;
    logic [7:0]         r_alarmCount;
    logic               r_siren;
    logic               r_strobe;
    logic               r_escalate;
    logic               r_ack;

    logic       w_codeOk;
    logic       w_codeBad;
    logic [1:0] w_badNext;

    assign w_codeOk  = bus.code_valid && (bus.code_in == DISARM_CODE);
    assign w_codeBad = bus.code_valid && (bus.code_in != DISARM_CODE);
    assign w_badNext = (r_badTries == 2'd3) ? 2'd3 : r_badTries + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_timer      <= '0;
            r_badTries   <= 2'd0;
            r_alarmCount <= 8'd0;
            r_siren      <= 1'b0;
            r_strobe     <= 1'b0;
            r_escalate   <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (bus.alarm_in) begin
                        r_state  <= S_SOUNDING;
                        r_siren  <= 1'b1;
                        r_strobe <= 1'b1;
                        r_phase  <= '0;
                        r_timer  <= '0;
                        if (r_alarmCount != 8'hFF) begin
                            r_alarmCount <= r_alarmCount + 8'd1;
                        end
                    end
                end

                S_SOUNDING: begin
                    if (r_phase == PHASE_LAST) begin
                        r_phase <= '0;
                        r_siren <= ~r_siren;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                    r_timer <= r_timer + 1'b1;

                    // A correct code beats both timeout and the try limit on the same edge.
                    if (w_codeOk) begin
                        r_state  <= S_ACKED;
                        r_siren  <= 1'b0;
                        r_strobe <= 1'b0;
                        r_ack    <= 1'b1;
                    end else begin
                        if (w_codeBad) begin
                            r_badTries <= w_badNext;
                        end
                        if ((w_codeBad && (w_badNext >= TRIES_MAX)) || (r_timer == TIMER_LAST)) begin
                            r_state    <= S_ESCALATED;
                            r_siren    <= 1'b1;
                            r_escalate <= 1'b1;
                        end
                    end
                end

                S_ESCALATED: begin
                    if (w_codeOk) begin
                        r_state    <= S_ACKED;
                        r_siren    <= 1'b0;
                        r_strobe   <= 1'b0;
                        r_escalate <= 1'b0;
                        r_ack      <= 1'b1;
                    end else if (w_codeBad) begin
                        r_badTries <= w_badNext;
                    end
                end

                S_ACKED: begin
                    // Hold here while the upstream alarm is still asserted so it cannot retrigger.
                    r_ack <= 1'b0;
                    if (!bus.alarm_in) begin
                        r_state    <= S_IDLE;
                        r_badTries <= 2'd0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.siren       = r_siren;
    assign bus.strobe      = r_strobe;
    assign bus.escalate    = r_escalate;
    assign bus.ack         = r_ack;
    assign bus.state_o     = r_state;
    assign bus.bad_tries   = r_badTries;
    assign bus.alarm_count = r_alarmCount;

endmodule

// File: tb/tb_alarm_responder.sv
// Directed bench for alarm_responder: outputs sampled on the falling edge,
// inputs changed on the falling edge, expectations written by hand.
module tb_alarm_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic sawEsc;
    logic [11:0] sirenPattern;

    alarm_responder_if #(.CODE_W(4)) bus ();

    alarm_responder #(
        .CODE_W     (4),
        .DISARM_CODE(4'h5),
        .BEEP_HALF  (4),
        .ESC_CYCLES (32),
        .MAX_TRIES  (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present a code for exactly one rising edge; returns on the next falling edge.
    task automatic applyStimulus(input logic [3:0] code);
        bus.code_valid = 1'b1;
        bus.code_in    = code;
        tick(1);
        bus.code_valid = 1'b0;
        bus.code_in    = 4'h0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        sawEsc         = 1'b0;
        sirenPattern   = 12'b1111_0000_1111;
        rst_n          = 1'b0;
        bus.alarm_in   = 1'b0;
        bus.code_valid = 1'b0;
        bus.code_in    = 4'h0;

        // Reset state
        tick(2);
        checkOutput("rst_state", 32'(bus.state_o), 32'd0);
        checkOutput("rst_siren", 32'(bus.siren), 32'd0);
        checkOutput("rst_strobe", 32'(bus.strobe), 32'd0);
        checkOutput("rst_escalate", 32'(bus.escalate), 32'd0);
        checkOutput("rst_ack", 32'(bus.ack), 32'd0);
        checkOutput("rst_bad", 32'(bus.bad_tries), 32'd0);
        checkOutput("rst_count", 32'(bus.alarm_count), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Codes are ignored in IDLE
        applyStimulus(4'h5);
        checkOutput("idle_code_state", 32'(bus.state_o), 32'd0);
        checkOutput("idle_code_ack", 32'(bus.ack), 32'd0);
        tick(1);

        // Trigger and siren pattern
        bus.alarm_in = 1'b1;
        tick(1);
        checkOutput("trig_state", 32'(bus.state_o), 32'd1);
        checkOutput("trig_strobe", 32'(bus.strobe), 32'd1);
        checkOutput("trig_count", 32'(bus.alarm_count), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            checkOutput($sformatf("siren_pat_%0d", k), 32'(bus.siren), 32'(sirenPattern[12-k]));
            tick(1);
        end
        tick(19);
        checkOutput("pre_esc_state", 32'(bus.state_o), 32'd1);
        checkOutput("pre_esc_escalate", 32'(bus.escalate), 32'd0);
        tick(1);
        checkOutput("esc_state", 32'(bus.state_o), 32'd2);
        checkOutput("esc_escalate", 32'(bus.escalate), 32'd1);
        checkOutput("esc_strobe", 32'(bus.strobe), 32'd1);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("esc_siren_%0d", k), 32'(bus.siren), 32'd1);
            tick(1);
        end

        // Wrong code in ESCALATED only counts
        applyStimulus(4'h9);
        checkOutput("esc_bad_count", 32'(bus.bad_tries), 32'd1);
        checkOutput("esc_bad_state", 32'(bus.state_o), 32'd2);

        // Acknowledge from ESCALATED
        applyStimulus(4'h5);
        checkOutput("ack_state", 32'(bus.state_o), 32'd3);
        checkOutput("ack_pulse", 32'(bus.ack), 32'd1);
        checkOutput("ack_siren", 32'(bus.siren), 32'd0);
        checkOutput("ack_strobe", 32'(bus.strobe), 32'd0);
        checkOutput("ack_escalate", 32'(bus.escalate), 32'd0);
        tick(1);
        checkOutput("ack_pulse_end", 32'(bus.ack), 32'd0);

        // Sticky alarm keeps ACKED
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("hold_%0d", k), {30'd0, bus.state_o} | 32'(bus.siren) << 4, 32'd3);
            tick(1);
        end
        bus.alarm_in = 1'b0;
        tick(1);
        checkOutput("idle_state", 32'(bus.state_o), 32'd0);
        checkOutput("idle_bad", 32'(bus.bad_tries), 32'd0);

        // Wrong codes reaching the try limit
        bus.alarm_in = 1'b1;
        tick(1);
        checkOutput("retrig_count", 32'(bus.alarm_count), 32'd2);
        applyStimulus(4'h1);
        checkOutput("try1_bad", 32'(bus.bad_tries), 32'd1);
        tick(2);
        applyStimulus(4'h2);
        checkOutput("try2_bad", 32'(bus.bad_tries), 32'd2);
        checkOutput("try2_state", 32'(bus.state_o), 32'd1);
        applyStimulus(4'h3);
        checkOutput("try3_state", 32'(bus.state_o), 32'd2);
        checkOutput("try3_bad", 32'(bus.bad_tries), 32'd3);
        checkOutput("try3_escalate", 32'(bus.escalate), 32'd1);
        applyStimulus(4'h5);
        checkOutput("try_ack_state", 32'(bus.state_o), 32'd3);
        checkOutput("try_ack_pulse", 32'(bus.ack), 32'd1);
        checkOutput("try_ack_siren", 32'(bus.siren), 32'd0);
        bus.alarm_in = 1'b0;
        tick(1);
        checkOutput("try_idle_bad", 32'(bus.bad_tries), 32'd0);

        // Correct code on the timer-expiry edge
        bus.alarm_in = 1'b1;
        tick(1);
        checkOutput("race_count", 32'(bus.alarm_count), 32'd3);
        for (int k = 1; k <= 31; k++) begin
            if (bus.escalate !== 1'b0) sawEsc = 1'b1;
            tick(1);
        end
        checkOutput("race_pre_state", 32'(bus.state_o), 32'd1);
        applyStimulus(4'h5);
        checkOutput("race_state", 32'(bus.state_o), 32'd3);
        checkOutput("race_no_esc", 32'(sawEsc | bus.escalate), 32'd0);
        bus.alarm_in = 1'b0;
        tick(1);
        checkOutput("race_idle", 32'(bus.state_o), 32'd0);

        // Final wrong code on the timer-expiry edge
        bus.alarm_in = 1'b1;
        tick(10);
        applyStimulus(4'h1);
        tick(9);
        applyStimulus(4'h2);
        tick(11);
        checkOutput("race2_pre_bad", 32'(bus.bad_tries), 32'd2);
        checkOutput("race2_pre_state", 32'(bus.state_o), 32'd1);
        applyStimulus(4'h7);
        checkOutput("race2_state", 32'(bus.state_o), 32'd2);
        checkOutput("race2_bad", 32'(bus.bad_tries), 32'd3);
        checkOutput("race2_count", 32'(bus.alarm_count), 32'd4);

        // Asynchronous reset in the middle of ESCALATED
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_state", 32'(bus.state_o), 32'd0);
        checkOutput("async_siren", 32'(bus.siren), 32'd0);
        checkOutput("async_strobe", 32'(bus.strobe), 32'd0);
        checkOutput("async_escalate", 32'(bus.escalate), 32'd0);
        checkOutput("async_ack", 32'(bus.ack), 32'd0);
        checkOutput("async_bad", 32'(bus.bad_tries), 32'd0);
        checkOutput("async_count", 32'(bus.alarm_count), 32'd0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
